// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, idle opcode and pipeline depth.
// The ALU and its dispatcher both import this package.
package alu_pkg;

    localparam int DATA_W  = 32;
    localparam int OP_W    = 6;
    localparam int ALU_LAT = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 6'd0,
        OP_SUB = 6'd1,
        OP_AND = 6'd2,
        OP_OR  = 6'd3,
        OP_SLT = 6'd4,
        OP_MUL = 6'd5
    } alu_op_e;

    // Opcode presented to the ALU on cycles with no real issue.
    localparam logic [OP_W-1:0] NOP_OP = 6'h3F;

    // Any opcode the ALU does not implement is accepted but reported as an error.
    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: op_illegal = 1'b0;
            default:                                       op_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_tag_pipe.sv
// Shift register carrying {valid, rd, err} alongside the ALU pipeline.
// It advances only when the ALU advances so the tail stage always
// describes the value currently on alu_result.
module alu_tag_pipe
    import alu_pkg::*;
#(
    parameter int DEPTH = alu_pkg::ALU_LAT,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             in_v,
    input  logic [TAG_W-1:0] in_rd,
    input  logic             in_err,
    output logic             any_v,
    output logic             tail_v,
    output logic [TAG_W-1:0] tail_rd,
    output logic             tail_err
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] err_q, err_d;
    logic [TAG_W-1:0] rd_q [DEPTH];
    logic [TAG_W-1:0] rd_d [DEPTH];

    // Next stage contents: clear drops only valids, enable shifts everything.
    always_comb begin
        v_d   = v_q;
        err_d = err_q;
        for (int i = 0; i < DEPTH; i++) rd_d[i] = rd_q[i];
        if (clr) begin
            v_d = '0;
        end else if (en) begin
            v_d[0]   = in_v;
            rd_d[0]  = in_rd;
            err_d[0] = in_err;
            for (int i = 1; i < DEPTH; i++) begin
                v_d[i]   = v_q[i-1];
                rd_d[i]  = rd_q[i-1];
                err_d[i] = err_q[i-1];
            end
        end
    end

    // Stage registers; reset wins over clear and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            err_q <= '0;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
        end else begin
            v_q   <= v_d;
            err_q <= err_d;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= rd_d[i];
        end
    end

    assign any_v    = |v_q;
    assign tail_v   = v_q[DEPTH-1];
    assign tail_rd  = rd_q[DEPTH-1];
    assign tail_err = err_q[DEPTH-1];

endmodule

// File: rtl/alu_dispatch.sv
// Issue/writeback wrapper around a fixed-latency external ALU.
// The ALU pipeline and the tag pipe advance together on alu_load; the
// single output buffer applies backpressure by stopping alu_load.
module alu_dispatch #(
    parameter int TAG_W   = 5,
    parameter int ALU_LAT = alu_pkg::ALU_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [alu_pkg::DATA_W-1:0] in_a,
    input  logic [alu_pkg::DATA_W-1:0] in_b,
    input  logic [alu_pkg::OP_W-1:0]   in_op,
    input  logic [TAG_W-1:0]           in_rd,
    output logic                       alu_load,
    output logic [alu_pkg::DATA_W-1:0] alu_a,
    output logic [alu_pkg::DATA_W-1:0] alu_b,
    output logic [alu_pkg::OP_W-1:0]   alu_op,
    input  logic [alu_pkg::DATA_W-1:0] alu_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [alu_pkg::DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]           out_rd,
    output logic                       out_err,
    output logic                       busy
);

    import alu_pkg::*;

    logic               adv;
    logic               fire;
    logic               tag_any_v;
    logic               tail_v;
    logic [TAG_W-1:0]   tail_rd;
    logic               tail_err;

    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0]   out_rd_q, out_rd_d;
    logic               out_err_q, out_err_d;

    // The pipe may move when not flushing and the output buffer has room
    // (empty, or being drained this edge). Reset holds everything still.
    assign adv      = !rst && !flush && (!out_valid_q || out_ready);
    assign in_ready = adv;
    assign fire     = in_valid && adv;
    assign alu_load = adv && (in_valid || tag_any_v);
    assign busy     = !rst && (tag_any_v || out_valid_q);

    assign alu_a  = fire ? in_a  : '0;
    assign alu_b  = fire ? in_b  : '0;
    assign alu_op = fire ? in_op : NOP_OP;

    alu_tag_pipe #(
        .DEPTH (ALU_LAT),
        .TAG_W (TAG_W)
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush),
        .en       (alu_load),
        .in_v     (fire),
        .in_rd    (in_rd),
        .in_err   (op_illegal(in_op)),
        .any_v    (tag_any_v),
        .tail_v   (tail_v),
        .tail_rd  (tail_rd),
        .tail_err (tail_err)
    );

    // Output buffer: capture the tail result when the ALU advances, else
    // release on handshake; data stays put while waiting for out_ready.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_err_d    = out_err_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (alu_load && tail_v) begin
            out_valid_d  = 1'b1;
            out_result_d = tail_err ? '0 : alu_result;
            out_rd_d     = tail_rd;
            out_err_d    = tail_err;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_err_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_err    = out_err_q;

endmodule
